// File: rtl/pixel_wr_if.sv
// Pixel write bus between the fractal engine and the write buffer,
// plus the frame-memory side of the buffer and its status flags.
interface pixel_wr_if;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_enable;
    logic        wait_request;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_we;
    logic        mem_ready;
    logic        frame_done;
    logic        align_err;

    modport slave (
        input  wr_addr, wr_data, wr_enable, mem_ready,
        output wait_request, mem_addr, mem_data, mem_we, frame_done, align_err
    );

    modport master (
        output wr_addr, wr_data, wr_enable, mem_ready,
        input  wait_request, mem_addr, mem_data, mem_we, frame_done, align_err
    );
endinterface

// File: rtl/pixel_wr_slave.sv
// Write-buffering slave: queues aligned pixel writes into a small FIFO that
// drains to frame memory, and pulses frame_done once each frame has drained.
//
// state      | meaning
// EMPTY      | no buffered entries
// PARTIAL    | 0 < count < DEPTH
// FULL       | count = DEPTH, master is held off
// DRAIN_DONE | last pixel of a frame was popped on the previous edge
module pixel_wr_slave #(
    parameter int DEPTH        = 4,
    parameter int FRAME_PIXELS = 307200
) (
    input  logic       clk,
    input  logic       rst,
    pixel_wr_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [19:0]   LAST_POP = 20'(FRAME_PIXELS - 1);

    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL, DRAIN_DONE} state_t;

    state_t        state;
    logic [31:0]   buf_addr [DEPTH];
    logic [31:0]   buf_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [19:0]   pop_cnt;
    logic          wait_request_r;
    logic          mem_we_r;
    logic          frame_done_r;
    logic          align_err_r;

    logic accept;
    logic push;
    logic pop;
    logic last_pop;

    assign accept   = bus.wr_enable & ~wait_request_r;
    assign push     = accept & (bus.wr_addr[1:0] == 2'b00);
    assign pop      = mem_we_r & bus.mem_ready;
    assign last_pop = pop & (pop_cnt == LAST_POP);

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage needs no reset: the head is only exposed while mem_we is high.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= bus.wr_addr;
            buf_data[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= EMPTY;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            pop_cnt        <= '0;
            wait_request_r <= 1'b1;
            mem_we_r       <= 1'b0;
            frame_done_r   <= 1'b0;
            align_err_r    <= 1'b0;
        end else begin
            count          <= count_nxt;
            wait_request_r <= (count_nxt == FULL_CNT);
            mem_we_r       <= (count_nxt != '0);
            frame_done_r   <= last_pop;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (accept && (bus.wr_addr[1:0] != 2'b00)) align_err_r <= 1'b1;
            if (last_pop)  pop_cnt <= '0;
            else if (pop)  pop_cnt <= pop_cnt + 1'b1;

            if (last_pop)                state <= DRAIN_DONE;
            else if (count_nxt == '0)    state <= EMPTY;
            else if (count_nxt == FULL_CNT) state <= FULL;
            else                         state <= PARTIAL;
        end
    end

    assign bus.wait_request = wait_request_r;
    assign bus.mem_we       = mem_we_r;
    assign bus.mem_addr     = mem_we_r ? buf_addr[rd_ptr] : 32'h0;
    assign bus.mem_data     = mem_we_r ? buf_data[rd_ptr] : 32'h0;
    assign bus.frame_done   = frame_done_r;
    assign bus.align_err    = align_err_r;

    logic unused_state;
    assign unused_state = (state == DRAIN_DONE);
endmodule
